// File: rtl/block_palette_renderer_pkg.sv
// block_palette_renderer_pkg: shared types and the default colour table
package block_palette_renderer_pkg;
  typedef enum logic [2:0] {EMPTY, CYAN, BLUE, ORANGE, YELLOW, GREEN, RED, MAGENTA} block_color;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pal_entry_t;
  localparam pal_entry_t DEFAULT_PALETTE [8] = '{
    '{8'h00, 8'h00, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'h00, 8'h00, 8'hFF},
    '{8'hFF, 8'hA5, 8'h00},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'h80, 8'h00},
    '{8'hFF, 8'h00, 8'h00},
    '{8'hFF, 8'h00, 8'hFF}
  };
  typedef enum logic [1:0] {IDLE, FLASH, DONE} flash_state_t;
endpackage

// File: rtl/block_palette_renderer_if.sv
// block_palette_renderer_if: pixel, palette-write, flash-control and VGA signals
interface block_palette_renderer_if #(
  parameter int CHAN_W = 8,
  parameter int CODE_W = 3
);
  logic                  pix_valid_in;
  logic                  play_area;
  logic [CODE_W-1:0]     block_type;
  logic                  ghost;
  logic                  flash_row;
  logic [9:0]            DrawX;
  logic [9:0]            DrawY;
  logic                  frame_start;
  logic                  flash_req;
  logic                  pal_we;
  logic [CODE_W-1:0]     pal_addr;
  logic [3*CHAN_W-1:0]   pal_wdata;
  logic                  flash_busy;
  logic                  flash_done;
  logic                  pix_valid_out;
  logic [CHAN_W-1:0]     VGA_R;
  logic [CHAN_W-1:0]     VGA_G;
  logic [CHAN_W-1:0]     VGA_B;
  modport master (
    output pix_valid_in, play_area, block_type, ghost, flash_row, DrawX, DrawY,
           frame_start, flash_req, pal_we, pal_addr, pal_wdata,
    input  flash_busy, flash_done, pix_valid_out, VGA_R, VGA_G, VGA_B
  );
  modport slave (
    input  pix_valid_in, play_area, block_type, ghost, flash_row, DrawX, DrawY,
           frame_start, flash_req, pal_we, pal_addr, pal_wdata,
    output flash_busy, flash_done, pix_valid_out, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/block_palette_renderer_flash_sequencer.sv
// block_palette_renderer_flash_sequencer: line-clear flash FSM with frame and toggle counters
module block_palette_renderer_flash_sequencer
  import block_palette_renderer_pkg::*;
#(
  parameter int FLASH_FRAMES  = 4,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic flash_req,
  output logic flash_on,
  output logic flash_busy,
  output logic flash_done
);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  flash_state_t state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TW-1:0] toggle_cnt_q, toggle_cnt_d;
  logic flash_on_q, flash_on_d;
  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      flash_on_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      flash_on_q   <= flash_on_d;
    end
  end
  // next state: count frames, invert flash_on each half-period, finish after the last toggle
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    flash_on_d   = flash_on_q;
    case (state_q)
      IDLE: if (flash_req) begin
        state_d      = FLASH;
        flash_on_d   = 1'b1;
        frame_cnt_d  = '0;
        toggle_cnt_d = '0;
      end
      FLASH: if (frame_start) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (frame_cnt_d == FW'(FLASH_FRAMES)) begin
          frame_cnt_d  = '0;
          flash_on_d   = !flash_on_q;
          toggle_cnt_d = toggle_cnt_q + 1'b1;
          if (toggle_cnt_d == TW'(FLASH_TOGGLES)) begin
            state_d    = DONE;
            flash_on_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign flash_on   = flash_on_q;
  assign flash_busy = state_q == FLASH;
  assign flash_done = state_q == DONE;
endmodule

// File: rtl/block_palette_renderer.sv
// block_palette_renderer: two-stage palette lookup with background, flash and ghost effects
module block_palette_renderer
  import block_palette_renderer_pkg::*;
#(
  parameter int CHAN_W        = 8,
  parameter int CODE_W        = 3,
  parameter int PAL_DEPTH     = 8,
  parameter int FLASH_FRAMES  = 4,
  parameter int FLASH_TOGGLES = 6,
  parameter int GHOST_SHIFT   = 2
) (
  input  logic Clk,
  input  logic Reset,
  block_palette_renderer_if.slave bus
);
  localparam int PW = 3 * CHAN_W;
  typedef struct packed {
    logic          valid;
    logic          play;
    logic          ghost;
    logic          frow;
    logic          nonempty;
    logic [6:0]    x;
    logic [PW-1:0] rgb;
  } s1_t;
  typedef struct packed {
    logic          valid;
    logic [PW-1:0] rgb;
  } out_t;
  function automatic logic [CHAN_W-1:0] sc(input logic [7:0] v);
    logic [CHAN_W+7:0] t;
    t = {v, {CHAN_W{1'b0}}};
    return t[CHAN_W+7 -: CHAN_W];
  endfunction
  function automatic logic [PW-1:0] def_entry(input int i);
    pal_entry_t e;
    e = i < 8 ? DEFAULT_PALETTE[i[2:0]] : '0;
    return {sc(e.r), sc(e.g), sc(e.b)};
  endfunction
  logic [PW-1:0] pal_q [PAL_DEPTH];
  logic [PW-1:0] pal_d [PAL_DEPTH];
  s1_t s1_q, s1_d;
  out_t out_q, out_d;
  logic flash_on;
  logic [CHAN_W-1:0] pr, pg, pb;
  logic unused;
  assign unused = ^{bus.DrawY, bus.DrawX[2:0]};
  block_palette_renderer_flash_sequencer #(
    .FLASH_FRAMES (FLASH_FRAMES),
    .FLASH_TOGGLES(FLASH_TOGGLES)
  ) u_seq (
    .clk        (Clk),
    .rst        (Reset),
    .frame_start(bus.frame_start),
    .flash_req  (bus.flash_req),
    .flash_on   (flash_on),
    .flash_busy (bus.flash_busy),
    .flash_done (bus.flash_done)
  );
  // palette, S1 and output registers; the palette reloads its defaults on reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) pal_q[i] <= def_entry(i);
      s1_q  <= '0;
      out_q <= '0;
    end else begin
      pal_q <= pal_d;
      s1_q  <= s1_d;
      out_q <= out_d;
    end
  end
  // palette write; S1 reads the pre-write entry, so same-address read returns the old value
  always_comb begin
    pal_d = pal_q;
    if (bus.pal_we && 32'(bus.pal_addr) < PAL_DEPTH) pal_d[bus.pal_addr] = bus.pal_wdata;
  end
  // S1: palette lookup and sideband capture
  always_comb begin
    s1_d.valid    = bus.pix_valid_in;
    s1_d.play     = bus.play_area;
    s1_d.ghost    = bus.ghost;
    s1_d.frow     = bus.flash_row;
    s1_d.nonempty = bus.block_type != '0;
    s1_d.x        = bus.DrawX[9:3];
    s1_d.rgb      = 32'(bus.block_type) < PAL_DEPTH ? pal_q[bus.block_type] : '0;
  end
  // S2: background, then flash white, then ghost dimming, then plain palette colour
  always_comb begin
    {pr, pg, pb} = s1_q.rgb;
    out_d.valid  = s1_q.valid;
    out_d.rgb    = !s1_q.play ? {sc(8'h1F), {CHAN_W{1'b0}}, sc(8'h7F - {1'b0, s1_q.x})} :
                   (s1_q.frow && flash_on) ? {PW{1'b1}} :
                   (s1_q.ghost && s1_q.nonempty) ? {pr >> GHOST_SHIFT, pg >> GHOST_SHIFT, pb >> GHOST_SHIFT} :
                   s1_q.rgb;
  end
  assign bus.pix_valid_out = out_q.valid;
  assign bus.VGA_R = out_q.rgb[PW-1 -: CHAN_W];
  assign bus.VGA_G = out_q.rgb[2*CHAN_W-1 -: CHAN_W];
  assign bus.VGA_B = out_q.rgb[CHAN_W-1:0];
endmodule

// File: tb/tb_block_palette_renderer.sv
// tb_block_palette_renderer: directed and random stimulus against a behavioural renderer model
module tb_block_palette_renderer;
  localparam int FF = 4;
  localparam int FT = 6;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;
  block_palette_renderer_if bus ();
  block_palette_renderer dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [23:0] mpal [8];
  logic s_valid, s_play, s_ghost, s_frow;
  logic [2:0] s_code;
  logic [9:0] s_x;
  logic [23:0] s_rgb;
  logic e_valid;
  logic [23:0] e_rgb;
  logic m_busy, m_done;
  int m_n;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [23:0] render(input logic fon);
    if (!s_play) return {8'h1F, 8'h00, 8'(127 - int'(s_x) / 8)};
    if (s_frow && fon) return 24'hFFFFFF;
    if (s_ghost && s_code != 0) return {s_rgb[23:16] >> 2, s_rgb[15:8] >> 2, s_rgb[7:0] >> 2};
    return s_rgb;
  endfunction
  task automatic model_reset();
    mpal = '{24'h000000, 24'h00FFFF, 24'h0000FF, 24'hFFA500,
             24'hFFFF00, 24'h008000, 24'hFF0000, 24'hFF00FF};
    {s_valid, s_play, s_ghost, s_frow, s_code, s_x, s_rgb} = '0;
    e_valid = 0;
    e_rgb = 0;
    m_busy = 0;
    m_done = 0;
    m_n = 0;
  endtask
  task automatic tick();
    logic chk_rgb;
    chk_rgb = Reset;
    if (Reset) model_reset();
    else begin
      e_valid = s_valid;
      e_rgb = render(m_busy && ((m_n / FF) % 2 == 0));
      chk_rgb = e_valid;
      s_valid = bus.pix_valid_in;
      s_play = bus.play_area;
      s_ghost = bus.ghost;
      s_frow = bus.flash_row;
      s_code = bus.block_type;
      s_x = bus.DrawX;
      s_rgb = mpal[bus.block_type];
      if (bus.pal_we) mpal[bus.pal_addr] = bus.pal_wdata;
      if (m_done) m_done = 0;
      else if (m_busy) begin
        if (bus.frame_start) begin
          m_n++;
          if (m_n == FF * FT) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (bus.flash_req) begin
        m_busy = 1;
        m_n = 0;
      end
    end
    @(posedge Clk);
    #1;
    check("valid", 32'(bus.pix_valid_out), 32'(e_valid));
    check("busy", 32'(bus.flash_busy), 32'(m_busy));
    check("done", 32'(bus.flash_done), 32'(m_done));
    if (chk_rgb) check("rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h0, e_rgb});
    bus.frame_start = 0;
    bus.flash_req = 0;
    bus.pal_we = 0;
  endtask
  task automatic pix(input logic play, input int code, input logic gh, input logic fr, input int x);
    bus.pix_valid_in = 1;
    bus.play_area = play;
    bus.block_type = 3'(code);
    bus.ghost = gh;
    bus.flash_row = fr;
    bus.DrawX = 10'(x);
  endtask
  initial begin
    {bus.pix_valid_in, bus.play_area, bus.block_type, bus.ghost, bus.flash_row, bus.DrawX,
     bus.DrawY, bus.frame_start, bus.flash_req, bus.pal_we, bus.pal_addr, bus.pal_wdata} = '0;
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    for (int c = 0; c < 8; c++) begin
      pix(1, c, 0, 0, 0);
      tick();
    end
    bus.pix_valid_in = 0;
    tick();
    tick();
    pix(0, 0, 0, 0, 0);    tick();
    pix(0, 0, 0, 0, 8);    tick();
    pix(0, 0, 0, 0, 1016); tick();
    pix(1, 3, 1, 0, 0);    tick();
    pix(1, 0, 1, 0, 0);    tick();
    pix(1, 2, 0, 0, 0);
    bus.pal_we = 1;
    bus.pal_addr = 2;
    bus.pal_wdata = 24'h123456;
    tick();
    pix(1, 2, 0, 0, 0);
    tick();
    pix(1, 6, 0, 1, 0);
    bus.flash_req = 1;
    tick();
    for (int k = 0; k < FF * FT; k++) begin
      tick();
      tick();
      bus.frame_start = 1;
      if (k == 10) bus.flash_req = 1;
      tick();
    end
    for (int k = 0; k < 4; k++) tick();
    bus.pal_we = 1;
    bus.pal_addr = 6;
    bus.pal_wdata = 24'h00FF00;
    bus.flash_req = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.frame_start = 1;
      tick();
    end
    Reset = 1;
    tick();
    Reset = 0;
    pix(1, 6, 0, 1, 0);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 4000; k++) begin
      bus.pix_valid_in = 1'($urandom);
      bus.play_area = $urandom_range(0, 3) != 0;
      bus.block_type = 3'($urandom);
      bus.ghost = $urandom_range(0, 3) == 0;
      bus.flash_row = 1'($urandom);
      bus.DrawX = 10'($urandom);
      bus.DrawY = 10'($urandom);
      bus.frame_start = $urandom_range(0, 3) == 0;
      bus.flash_req = $urandom_range(0, 39) == 0;
      bus.pal_we = $urandom_range(0, 9) == 0;
      bus.pal_addr = 3'($urandom);
      bus.pal_wdata = 24'($urandom);
      Reset = $urandom_range(0, 499) == 0;
      tick();
    end
    Reset = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
